// File: rtl/loop_gain_probe_nch.sv
// Loop-gain probe: DDS tone injection plus synchronous I/Q demodulation of NCH
// before/after probe pairs, with the per-channel sums read out as handshaked result beats.
module loop_gain_probe_nch #(
  parameter int NCH     = 2,
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int WIN_W   = 16,
  parameter int ACC_W   = 44,
  parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [PHASE_W-1:0]              tone_step,
  input  logic [WIN_W-1:0]                win_len,
  input  logic                            s_valid,
  input  logic [NCH*DATA_W-1:0]           s_in,
  input  logic [NCH*DATA_W-1:0]           s_out,
  output logic signed [DATA_W-1:0]        inj_out,
  output logic                            busy,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [CH_W-1:0]                 m_chan,
  output logic signed [ACC_W-1:0]         m_in_i,
  output logic signed [ACC_W-1:0]         m_in_q,
  output logic signed [ACC_W-1:0]         m_out_i,
  output logic signed [ACC_W-1:0]         m_out_q,
  output logic                            done,
  output logic                            overrun
);

  localparam int  LUT_N = 2 ** LUT_AW;
  localparam int  PW    = 2 * DATA_W;
  localparam real PI    = 3.14159265358979323846;

  function automatic int round_real(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  // Full-period table evaluated at elaboration; angle folded into [-pi, pi) so the series converges fast.
  function automatic logic [LUT_N*DATA_W-1:0] build_sin_lut();
    logic [LUT_N*DATA_W-1:0] tbl;
    real x, term, sum, amp;
    int  kk, v;
    tbl = '0;
    amp = $itor((2 ** (DATA_W - 1)) - 1);
    for (int k = 0; k < LUT_N; k++) begin
      kk = (k < LUT_N / 2) ? k : k - LUT_N;
      x = 2.0 * PI * $itor(kk) / $itor(LUT_N);
      term = x;
      sum = x;
      for (int n = 1; n < 14; n++) begin
        term = -term * x * x / $itor((2 * n) * (2 * n + 1));
        sum = sum + term;
      end
      v = round_real(amp * sum);
      tbl[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
    end
    return tbl;
  endfunction

  localparam logic [LUT_N*DATA_W-1:0] SIN_LUT = build_sin_lut();

  function automatic logic signed [DATA_W-1:0] lut_at(input logic [LUT_AW-1:0] k);
    return SIN_LUT[32'(k)*DATA_W +: DATA_W];
  endfunction

  function automatic logic signed [PW-1:0] mul_full(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    logic signed [PW-1:0] ae, be;
    ae = {{DATA_W{a[DATA_W-1]}}, a};
    be = {{DATA_W{b[DATA_W-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DUMP} state_t;
  state_t              state;
  logic [PHASE_W-1:0]  phase, tstep;
  logic [WIN_W-1:0]    cnt, wlen;
  logic                drain_cnt;

  logic [LUT_AW-1:0]        k_sin, k_cos;
  logic signed [DATA_W-1:0] sin_v, cos_v;
  logic                     start_ok, take;

  assign k_sin    = phase[PHASE_W-1 -: LUT_AW];
  assign k_cos    = k_sin + LUT_AW'(LUT_N / 4);
  assign sin_v    = lut_at(k_sin);
  assign cos_v    = lut_at(k_cos);
  assign start_ok = (state == IDLE) && start && (win_len != '0);
  assign take     = (state == ACC) && s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      tstep     <= '0;
      cnt       <= '0;
      wlen      <= '0;
      drain_cnt <= 1'b0;
      inj_out   <= '0;
      busy      <= 1'b0;
      m_valid   <= 1'b0;
      m_chan    <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          inj_out <= '0;
          if (start_ok) begin
            tstep   <= tone_step;
            wlen    <= win_len;
            cnt     <= '0;
            phase   <= '0;
            overrun <= 1'b0;
            busy    <= 1'b1;
            state   <= ACC;
          end
        end
        ACC: begin
          inj_out <= sin_v;
          if (s_valid) begin
            phase <= phase + tstep;
            cnt   <= cnt + WIN_W'(1);
            if (cnt + WIN_W'(1) == wlen) begin
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          inj_out <= sin_v;
          if (s_valid) overrun <= 1'b1;
          if (drain_cnt) begin
            m_valid <= 1'b1;
            m_chan  <= '0;
            state   <= DUMP;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DUMP: begin
          inj_out <= sin_v;
          if (s_valid) overrun <= 1'b1;
          if (m_ready) begin
            if (m_chan == CH_W'(NCH - 1)) begin
              m_valid <= 1'b0;
              m_chan  <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              inj_out <= '0;
              state   <= IDLE;
            end else begin
              m_chan <= m_chan + CH_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: full-precision products of the accepted sample against sin/cos of its phase
  logic                    vld_p0;
  logic signed [PW-1:0]    in_i_p0 [NCH];
  logic signed [PW-1:0]    in_q_p0 [NCH];
  logic signed [PW-1:0]    out_i_p0 [NCH];
  logic signed [PW-1:0]    out_q_p0 [NCH];

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= take;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      in_i_p0[c]  <= mul_full($signed(s_in[c*DATA_W +: DATA_W]), sin_v);
      in_q_p0[c]  <= mul_full($signed(s_in[c*DATA_W +: DATA_W]), cos_v);
      out_i_p0[c] <= mul_full($signed(s_out[c*DATA_W +: DATA_W]), sin_v);
      out_q_p0[c] <= mul_full($signed(s_out[c*DATA_W +: DATA_W]), cos_v);
    end
  end

  // Stage p1: wrapping accumulators, cleared by reset and by an accepted start
  logic signed [ACC_W-1:0] in_i_p1 [NCH];
  logic signed [ACC_W-1:0] in_q_p1 [NCH];
  logic signed [ACC_W-1:0] out_i_p1 [NCH];
  logic signed [ACC_W-1:0] out_q_p1 [NCH];

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || start_ok) begin
        in_i_p1[c]  <= '0;
        in_q_p1[c]  <= '0;
        out_i_p1[c] <= '0;
        out_q_p1[c] <= '0;
      end else if (vld_p0) begin
        in_i_p1[c]  <= in_i_p1[c]  + sext_prod(in_i_p0[c]);
        in_q_p1[c]  <= in_q_p1[c]  + sext_prod(in_q_p0[c]);
        out_i_p1[c] <= out_i_p1[c] + sext_prod(out_i_p0[c]);
        out_q_p1[c] <= out_q_p1[c] + sext_prod(out_q_p0[c]);
      end
    end
  end

  assign m_in_i  = in_i_p1[m_chan];
  assign m_in_q  = in_q_p1[m_chan];
  assign m_out_i = out_i_p1[m_chan];
  assign m_out_q = out_q_p1[m_chan];

endmodule

// File: tb/tb_loop_gain_probe_nch.sv
// Directed bench for loop_gain_probe_nch (NCH=2): tone demodulation, result readout,
// overrun, ignored starts and mid-measurement reset.
module tb_loop_gain_probe_nch;
  localparam int NCH = 2, DATA_W = 12, PHASE_W = 16, WIN_W = 16, ACC_W = 44, CH_W = 1;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic [PHASE_W-1:0]          tone_step = '0;
  logic [WIN_W-1:0]            win_len = '0;
  logic                        s_valid = 1'b0;
  logic [NCH*DATA_W-1:0]       s_in = '0;
  logic [NCH*DATA_W-1:0]       s_out = '0;
  logic signed [DATA_W-1:0]    inj_out;
  logic                        busy, m_valid, done, overrun;
  logic                        m_ready = 1'b0;
  logic [CH_W-1:0]             m_chan;
  logic signed [ACC_W-1:0]     m_in_i, m_in_q, m_out_i, m_out_q;

  int checks = 0;
  int errors = 0;

  loop_gain_probe_nch #(.NCH(NCH), .DATA_W(DATA_W), .PHASE_W(PHASE_W), .LUT_AW(8),
                        .WIN_W(WIN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .tone_step(tone_step), .win_len(win_len),
    .s_valid(s_valid), .s_in(s_in), .s_out(s_out), .inj_out(inj_out), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_in_i(m_in_i), .m_in_q(m_in_q),
    .m_out_i(m_out_i), .m_out_q(m_out_q), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [PHASE_W-1:0] step, input logic [WIN_W-1:0] len);
    start = 1'b1; tone_step = step; win_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic signed [DATA_W-1:0] i0, input logic signed [DATA_W-1:0] i1,
                      input logic signed [DATA_W-1:0] o0, input logic signed [DATA_W-1:0] o1);
    s_valid = 1'b1; s_in = {i1, i0}; s_out = {o1, o0};
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, m_valid, 1);
  endtask

  task automatic check_beat(input string tag, input int ch, input longint ii, input longint iq,
                            input longint oi, input longint oq);
    check({tag, "_chan"}, m_chan, ch);
    check({tag, "_in_i"}, m_in_i, ii);
    check({tag, "_in_q"}, m_in_q, iq);
    check({tag, "_out_i"}, m_out_i, oi);
    check({tag, "_out_q"}, m_out_q, oq);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_inj", inj_out, 0);
    check("rst_in_i", m_in_i, 0);

    // zero-length window is ignored
    do_start(16'h4000, 0);
    check("zero_len_busy", busy, 0);
    @(negedge clk);
    check("zero_len_busy2", busy, 0);

    // quarter-period tone, 4-sample window
    do_start(16'h4000, 4);
    check("t1_busy", busy, 1);
    send(100, 1, 0, 2047);     check("t1_inj0", inj_out, 0);
    send(100, 2, 2047, 0);     check("t1_inj1", inj_out, 2047);
    send(100, 3, 0, -2047);    check("t1_inj2", inj_out, 0);
    send(100, 4, -2047, 0);    check("t1_inj3", inj_out, -2047);
    s_valid = 1'b0;
    wait_valid("t1_wait");
    for (int r = 0; r < 5; r++) begin
      check_beat("t3_ch0", 0, 0, 0, 8380418, 0);
      check("t3_ch0_valid", m_valid, 1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      check_beat("t3_ch1", 1, -4094, -4094, 0, 8380418);
      check("t3_ch1_busy", busy, 1);
      check("t3_ch1_done", done, 0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("t3_done", done, 1);
    check("t3_busy_off", busy, 0);
    check("t3_mvalid_off", m_valid, 0);
    check("t3_inj_idle", inj_out, 0);
    check("t3_overrun", overrun, 0);
    @(negedge clk);
    check("t3_done_pulse", done, 0);

    // overrun with s_valid held high; extra starts while busy are ignored
    do_start(16'h4000, 2);
    do_start(16'h4000, 7);
    check("t6_busy_kept", busy, 1);
    send(10, 0, 0, 0);
    send(20, 0, 0, 0);
    s_in = {12'sd0, 12'sd999};
    wait_valid("t4_wait");
    check("t4_overrun", overrun, 1);
    start = 1'b1; win_len = 3;
    @(negedge clk);
    start = 1'b0;
    check("t6_dump_valid", m_valid, 1);
    check_beat("t4_ch0", 0, 40940, 20470, 0, 0);
    m_ready = 1'b1;
    @(negedge clk);
    check_beat("t4_ch1", 1, 0, 0, 0, 0);
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
    check("t4_done", done, 1);
    check("t4_overrun_sticky", overrun, 1);

    // next accepted start clears overrun; single-sample window
    do_start(16'h1234, 1);
    check("t4_overrun_clr", overrun, 0);
    send(0, 7, -3, 0);
    s_valid = 1'b0;
    wait_valid("w1_wait");
    check_beat("w1_ch0", 0, 0, 0, 0, -6141);
    m_ready = 1'b1;
    @(negedge clk);
    check_beat("w1_ch1", 1, 0, 14329, 0, 0);
    @(negedge clk);
    m_ready = 1'b0;
    check("w1_done", done, 1);

    // reset in the middle of accumulation
    do_start(16'h4000, 4);
    send(5, 5, 5, 5);
    send(5, 5, 5, 5);
    s_valid = 1'b0;
    check("t5_inj_pre", inj_out, 2047);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_inj", inj_out, 0);
    check("t5_mvalid", m_valid, 0);
    seen = 0;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      if (m_valid || done || busy) seen++;
    end
    check("t5_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
